// File: rtl/ring_slot_arbiter.sv
// ring_slot_arbiter
//   Shares one core's ring-append opportunity between NREQ local ring clients.
//   On a Token slot the arbiter picks one requesting client (round robin),
//   appends that client's burst length to the token's 8-bit train count,
//   waits out the existing train and then opens a send window of len cycles
//   during which the granted client drives its slots.
//
// Optional feature macro: RING_ARB_PRIO_EN
//   defined   : client 0 has fixed priority; the rr pointer rotates over 1..NREQ-1
//   undefined : pure round robin over all NREQ clients
//
// Ports
//   clock        in   system clock
//   reset        in   synchronous active-low reset
//   req          in   [NREQ]      per-client burst request (level)
//   reqLen       in   [NREQ*LENW] per-client burst length, 0 treated as 1
//   RingIn       in   [32]        ring data input
//   SlotTypeIn   in   [4]         ring slot type input
//   grant        out  [NREQ]      one-hot committed client
//   sendSlot     out              granted client drives its slot this cycle
//   sendIdx      out  [LENW]      index of the current slot in the window
//   sendLast     out              last slot of the window
//   arbRingOut   out  [32]        token data with appended count
//   arbDriveRing out              arbiter drives the ring this cycle
//   arbWaiting   out              waiting for a token
module ring_slot_arbiter #(
  parameter int         NREQ  = 2,
  parameter int         LENW  = 4,
  parameter logic [3:0] TOKEN = 4'd1
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [NREQ-1:0]        req,
  input  logic [NREQ*LENW-1:0]   reqLen,
  input  logic [31:0]            RingIn,
  input  logic [3:0]             SlotTypeIn,
  output logic [NREQ-1:0]        grant,
  output logic                   sendSlot,
  output logic [LENW-1:0]        sendIdx,
  output logic                   sendLast,
  output logic [31:0]            arbRingOut,
  output logic                   arbDriveRing,
  output logic                   arbWaiting
);

  localparam int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int RRN  = (NREQ > 1) ? (NREQ - 1) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NREQ - 1);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WAIT_TOKEN = 2'd1,
    WAIT_N     = 2'd2,
    SEND       = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [NREQ-1:0]   grant_q, grant_d;
  logic [7:0]        cnt_q,   cnt_d;
  logic [LENW-1:0]   len_q,   len_d;
  logic [LENW-1:0]   idx_q,   idx_d;
  logic [IDXW-1:0]   win_q,   win_d;
  logic [IDXW-1:0]   rr_q,    rr_d;

  logic [IDXW-1:0]   win_s;
  logic              found_s;
  logic [LENW-1:0]   raw_len_s;
  logic [LENW-1:0]   len_s;
  logic [8:0]        sum_s;
  logic              take_s;
  logic [IDXW-1:0]   rr_next_s;
  logic [LENW-1:0]   last_idx_s;

  // Winner search: first requesting client at or after the rr pointer.
  always_comb begin
    int c;
    int base;
    win_s   = '0;
    found_s = 1'b0;
    c       = 0;
    base    = 0;
`ifdef RING_ARB_PRIO_EN
    // Client 0 wins outright; the rotation only covers clients 1..NREQ-1,
    // and an rr value of 0 (reset) behaves like 1.
    if (req[0]) begin
      win_s   = '0;
      found_s = 1'b1;
    end else begin
      base = (rr_q == '0) ? 0 : (int'(rr_q) - 1);
      for (int k = 0; k < NREQ - 1; k++) begin
        c = 1 + ((base + k) % RRN);
        if (!found_s && req[c]) begin
          win_s   = c[IDXW-1:0];
          found_s = 1'b1;
        end
      end
    end
`else
    for (int k = 0; k < NREQ; k++) begin
      c = (int'(rr_q) + k) % NREQ;
      if (!found_s && req[c]) begin
        win_s   = c[IDXW-1:0];
        found_s = 1'b1;
      end
    end
`endif
  end

  // Winner's burst length (0 means 1) and the 9-bit count sum for saturation.
  always_comb begin
    raw_len_s = reqLen[int'(win_s)*LENW +: LENW];
    if (raw_len_s == '0) begin
      len_s = LENW'(1);
    end else begin
      len_s = raw_len_s;
    end
    sum_s  = {1'b0, RingIn[7:0]} + 9'(len_s);
    // Append only when the token is present, someone still requests and the
    // count does not overflow; an overflowing token passes untouched.
    take_s = (state_q == WAIT_TOKEN) && (|req) && found_s &&
             (SlotTypeIn == TOKEN) && !sum_s[8];
  end

  // Pointer value after the current window completes.
  always_comb begin
`ifdef RING_ARB_PRIO_EN
    if (win_q == '0) begin
      rr_next_s = rr_q;
    end else if (win_q == LAST_IDX) begin
      rr_next_s = IDXW'(1);
    end else begin
      rr_next_s = win_q + IDXW'(1);
    end
`else
    if (win_q == LAST_IDX) begin
      rr_next_s = '0;
    end else begin
      rr_next_s = win_q + IDXW'(1);
    end
`endif
  end

  assign last_idx_s = len_q - LENW'(1);

  // Next-state logic for the arbitration FSM.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    idx_d   = idx_q;
    win_d   = win_q;
    rr_d    = rr_q;
    case (state_q)
      IDLE: begin
        if (|req) begin
          state_d = WAIT_TOKEN;
        end else begin
          state_d = IDLE;
        end
      end
      WAIT_TOKEN: begin
        if (!(|req)) begin
          state_d = IDLE;
        end else if (take_s) begin
          grant_d        = '0;
          grant_d[win_s] = 1'b1;
          win_d          = win_s;
          len_d          = len_s;
          idx_d          = '0;
          // L counts the slots already in the train behind this token.
          if (RingIn[7:0] == 8'd0) begin
            state_d = SEND;
          end else begin
            cnt_d   = RingIn[7:0];
            state_d = WAIT_N;
          end
        end else begin
          state_d = WAIT_TOKEN;
        end
      end
      WAIT_N: begin
        cnt_d = cnt_q - 8'd1;
        if (cnt_q == 8'd1) begin
          state_d = SEND;
        end else begin
          state_d = WAIT_N;
        end
      end
      SEND: begin
        if (idx_q == last_idx_s) begin
          state_d = IDLE;
          grant_d = '0;
          idx_d   = '0;
          rr_d    = rr_next_s;
        end else begin
          idx_d = idx_q + LENW'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= IDLE;
      grant_q <= '0;
      cnt_q   <= 8'd0;
      len_q   <= LENW'(1);
      idx_q   <= '0;
      win_q   <= '0;
      rr_q    <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      win_q   <= win_d;
      rr_q    <= rr_d;
    end
  end

  assign grant        = grant_q;
  assign sendSlot     = (state_q == SEND);
  assign sendIdx      = idx_q;
  assign sendLast     = (state_q == SEND) && (idx_q == last_idx_s);
  assign arbWaiting   = (state_q == WAIT_TOKEN);
  assign arbDriveRing = take_s;
  assign arbRingOut   = take_s ? {RingIn[31:8], sum_s[7:0]} : RingIn;

endmodule

// File: tb/tb_ring_slot_arbiter.sv
module tb_ring_slot_arbiter;

  localparam logic [3:0] TOK = 4'd1;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [1:0]  req = 2'b00;
  logic [7:0]  reqLen = 8'h00;
  logic [31:0] RingIn = 32'h0;
  logic [3:0]  SlotTypeIn = 4'd0;
  logic [1:0]  grant;
  logic        sendSlot;
  logic [3:0]  sendIdx;
  logic        sendLast;
  logic [31:0] arbRingOut;
  logic        arbDriveRing;
  logic        arbWaiting;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  typedef struct {
    int          c;
    logic        drv;
    logic [1:0]  g;
    logic [3:0]  ix;
    logic        lst;
    logic [31:0] r;
  } ev_t;

  ev_t q[$];

  ring_slot_arbiter #(.NREQ(2), .LENW(4), .TOKEN(TOK)) dut (
    .clock        (clock),
    .reset        (reset),
    .req          (req),
    .reqLen       (reqLen),
    .RingIn       (RingIn),
    .SlotTypeIn   (SlotTypeIn),
    .grant        (grant),
    .sendSlot     (sendSlot),
    .sendIdx      (sendIdx),
    .sendLast     (sendLast),
    .arbRingOut   (arbRingOut),
    .arbDriveRing (arbDriveRing),
    .arbWaiting   (arbWaiting)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  // Monitor: every drive or send cycle must match the next expected event.
  always @(negedge clock) begin
    ev_t e;
    if (arbDriveRing || sendSlot) begin
      checks++;
      if (q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_output cyc=%0d drv=%b slot=%b gnt=%b idx=%0d ring=%h",
                 cyc, arbDriveRing, sendSlot, grant, sendIdx, arbRingOut);
      end else begin
        e = q.pop_front();
        if (cyc != e.c || arbDriveRing !== e.drv || sendSlot !== !e.drv ||
            grant !== e.g || sendIdx !== e.ix || sendLast !== e.lst ||
            (e.drv && arbRingOut !== e.r)) begin
          failures++;
          $display("FAIL event got cyc=%0d drv=%b slot=%b gnt=%b idx=%0d last=%b ring=%h expected cyc=%0d drv=%b gnt=%b idx=%0d last=%b ring=%h",
                   cyc, arbDriveRing, sendSlot, grant, sendIdx, sendLast, arbRingOut,
                   e.c, e.drv, e.g, e.ix, e.lst, e.r);
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", n, act, exp);
    end
  endtask

  task automatic exp_drv(input int c, input logic [7:0] cnt);
    ev_t e;
    e.c = c; e.drv = 1'b1; e.g = 2'b00; e.ix = 4'd0; e.lst = 1'b0;
    e.r = {24'h5AC30F, cnt};
    q.push_back(e);
  endtask

  task automatic exp_win(input int start, input logic [1:0] g, input int n);
    ev_t e;
    for (int i = 0; i < n; i++) begin
      e.c = start + i; e.drv = 1'b0; e.g = g; e.ix = 4'(i);
      e.lst = (i == n - 1); e.r = 32'h0;
      q.push_back(e);
    end
  endtask

  task automatic tok(input logic [7:0] l);
    SlotTypeIn = TOK;
    RingIn     = {24'h5AC30F, l};
    step(1);
    SlotTypeIn = 4'd0;
    RingIn     = 32'h0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    req   = 2'b00;
    step(1);
    reset = 1'b1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired at cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    logic [1:0] g;

    // Reset state.
    reset = 1'b0;
    step(2);
    chk("rst_grant",   32'(grant), 32'd0);
    chk("rst_slot",    32'(sendSlot), 32'd0);
    chk("rst_idx",     32'(sendIdx), 32'd0);
    chk("rst_last",    32'(sendLast), 32'd0);
    chk("rst_drive",   32'(arbDriveRing), 32'd0);
    chk("rst_waiting", 32'(arbWaiting), 32'd0);
    reset = 1'b1;

    // 1: single client, len 1, empty train.
    reqLen = {4'd4, 4'd1};
    req = 2'b01;
    step(1);
    chk("t1_waiting", 32'(arbWaiting), 32'd1);
    t = cyc;
    exp_drv(t, 8'd1);
    exp_win(t + 1, 2'b01, 1);
    tok(8'd0);
    req = 2'b00;
    step(2);
    chk("t1_grant_clear", 32'(grant), 32'd0);
    chk("t1_idle", 32'(arbWaiting), 32'd0);

    // 2: both request, count 3, lens 2/4, then rotation.
    do_reset();
    reqLen = {4'd4, 4'd2};
    req = 2'b11;
    step(1);
    t = cyc;
    exp_drv(t, 8'd5);
    exp_win(t + 4, 2'b01, 2);
    tok(8'd3);
    step(6);
    chk("t2_waiting2", 32'(arbWaiting), 32'd1);
    t = cyc;
`ifdef RING_ARB_PRIO_EN
    exp_drv(t, 8'd2);
    exp_win(t + 1, 2'b01, 2);
`else
    exp_drv(t, 8'd4);
    exp_win(t + 1, 2'b10, 4);
`endif
    tok(8'd0);
    req = 2'b00;
    step(5);
    chk("t2_grant_clear", 32'(grant), 32'd0);

    // 3: non-token slot ignored, saturated token skipped, next token used.
    do_reset();
    reqLen = {4'd4, 4'd2};
    req = 2'b01;
    step(1);
    SlotTypeIn = 4'd2;
    RingIn = 32'h5AC30F00;
    step(1);
    SlotTypeIn = 4'd0;
    tok(8'd254);
    chk("t3_sat_waiting", 32'(arbWaiting), 32'd1);
    chk("t3_sat_grant", 32'(grant), 32'd0);
    t = cyc;
    exp_drv(t, 8'd12);
    exp_win(t + 11, 2'b01, 2);
    tok(8'd10);
    req = 2'b00;
    step(14);
    chk("t3_grant_clear", 32'(grant), 32'd0);

    // 4: request drops mid-window; window still completes.
    do_reset();
    reqLen = {4'd4, 4'd3};
    req = 2'b01;
    step(1);
    t = cyc;
    exp_drv(t, 8'd3);
    exp_win(t + 1, 2'b01, 3);
    tok(8'd0);
    step(1);
    req = 2'b00;
    step(1);
    chk("t4_grant_held", 32'(grant), 32'd1);
    step(1);
    chk("t4_grant_clear", 32'(grant), 32'd0);
    chk("t4_slot_clear", 32'(sendSlot), 32'd0);

    // 5: reset during WAIT_N abandons the window.
    do_reset();
    reqLen = {4'd4, 4'd1};
    req = 2'b01;
    step(1);
    t = cyc;
    exp_drv(t, 8'd6);
    tok(8'd5);
    step(1);
    chk("t5_grant_waitn", 32'(grant), 32'd1);
    reset = 1'b0;
    req = 2'b00;
    step(1);
    chk("t5_grant", 32'(grant), 32'd0);
    chk("t5_waiting", 32'(arbWaiting), 32'd0);
    chk("t5_drive", 32'(arbDriveRing), 32'd0);
    chk("t5_slot", 32'(sendSlot), 32'd0);
    reset = 1'b1;
    step(10);

    // 7: zero length means one slot; count 254+1 reaches 255 exactly.
    do_reset();
    reqLen = {4'd4, 4'd0};
    req = 2'b01;
    step(1);
    t = cyc;
    exp_drv(t, 8'd255);
    exp_win(t + 255, 2'b01, 1);
    tok(8'd254);
    req = 2'b00;
    step(256);
    chk("t7_grant_clear", 32'(grant), 32'd0);

    // 8: request withdrawn before the token arrives.
    do_reset();
    req = 2'b01;
    step(1);
    chk("t8_waiting", 32'(arbWaiting), 32'd1);
    req = 2'b00;
    step(1);
    chk("t8_idle", 32'(arbWaiting), 32'd0);
    tok(8'd0);
    step(2);

    // 6: repeated tokens with both clients requesting.
    do_reset();
    reqLen = {4'd1, 4'd1};
    req = 2'b11;
    step(1);
    for (int k = 0; k < 3; k++) begin
      t = cyc;
`ifdef RING_ARB_PRIO_EN
      g = 2'b01;
`else
      g = (k % 2 == 1) ? 2'b10 : 2'b01;
`endif
      exp_drv(t, 8'd1);
      exp_win(t + 1, g, 1);
      tok(8'd0);
      step(2);
    end
    req = 2'b00;
    step(3);

    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
